mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter: ACK_LIMIT, default 0, max cycles in WAIT without dack (0 = unbounded).
REQ-002 Ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of held/in-flight op
- ex_valid  in  1  EX offers an op
- ex_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; 11-15 treated as NONE
- ex_addr  in  32  effective address
- ex_sdata  in  32  store data
- ex_wd / ex_wreg / ex_wdata  in  5/1/32  destination, write enable, ALU result
- ex_pc / ex_instr  in  32/32  debug tags
- llbit_cur  in  1  current LLbit, WB-forwarded
- mem_ready  out  1  op accepted on this edge when ex_valid=1
- stall_req  out  1  equals ~mem_ready
- dreq / dwe  out  1/1  bus request, write
- daddr  out  32  {addr[31:2],2'b00}
- dbe  out  4  byte enables
- dwdata  out  32  store data
- dack  in  1  bus completion
- drdata  in  32  load word
- mem_wd / mem_wreg / mem_wdata  out  5/1/32  to MEM/WB
- mem_inst_pc / mem_instr  out  32/32  to MEM/WB
- mem_inst_valid  out  1  1 = real completing instruction this cycle
- mem_LLbit_we / mem_LLbit_value  out  1/1  LLbit update
- mem_excp_ale / mem_excp_bus  out  1/1  misaligned access / bus timeout

Function
REQ-003 States: EMPTY, EXEC, WAIT; one held op registered at accept.
REQ-004 mem_ready = (state==EMPTY) | completion this cycle; no accept while a held op does not complete.
REQ-005 Accept: NONE, misaligned, or SC with llbit_cur=0 -> EXEC; other memory ops -> WAIT; no accept -> EMPTY.
REQ-006 Misaligned: LH/LHU/SH addr[0]=1; LW/SW/LL/SC addr[1:0]!=0; no bus access.
REQ-007 EXEC completes in its single cycle (latency 1); WAIT completes in the cycle dack=1 (same-cycle load data, no extra register).
REQ-008 dreq=1 throughout WAIT; daddr/dwe/dbe/dwdata stable until dack; dack ignored when dreq=0; dack in first WAIT cycle legal.
REQ-009 Stores: SB dbe=1<<addr[1:0], data={4{b}}; SH dbe=addr[1]?1100:0011, data={2{h}}; SW/SC dbe=1111.
REQ-010 Loads: dbe=1111, dwe=0; LB/LH sign-extend, LBU/LHU zero-extend selected byte/half; LW/LL full word.
REQ-011 Completion outputs: mem_inst_valid=1; pc/instr/wd from held op; wdata = load data for loads, ex_wdata for NONE/stores, 1 for SC success, 0 for SC fail.
REQ-012 mem_wreg = held ex_wreg, forced 0 on stores (not SC) and on any exception.
REQ-013 LL: LLbit_we=1, value 1; SC (success or fail): LLbit_we=1, value 0; otherwise LLbit_we=0.
REQ-014 Misaligned completes in EXEC with mem_excp_ale=1, mem_wreg=0, LLbit_we=0.
REQ-015 ACK_LIMIT>0: cycle counter in WAIT; at ACK_LIMIT cycles without dack, dreq drops, op completes with mem_excp_bus=1, mem_wreg=0, LLbit_we=0.
REQ-016 Non-completing cycles: mem_inst_valid, mem_wreg, mem_LLbit_we, excp outputs = 0; data outputs = 0.
REQ-017 flush in EMPTY/EXEC: held op dropped, no completion; same-edge accept suppressed.
REQ-018 flush in WAIT: dreq held until dack or timeout, result discarded (bubble), then EMPTY; killed flag persists across cycles.
REQ-019 flush and dack same cycle: outputs bubble, state -> EMPTY.

Reset
REQ-020 rst=0: state EMPTY, counter 0, killed 0, all outputs 0 except mem_ready=1, stall_req=0, asynchronously, including mid-WAIT (dreq drops immediately).
REQ-021 First accept on first rising edge after rst deasserts.

Verification
REQ-022 NONE op, wd=3, wdata=0x5 -> next cycle mem_inst_valid=1, wreg=1, wdata=0x5, dreq=0.
REQ-023 LB addr 0x1003, dack after 3 cycles, drdata=0x80112233 -> stall_req=1 for 3 cycles; completion wdata=0xFFFFFF80.
REQ-024 SH addr 0x2002, sdata=0xABCD1234 -> dbe=1100, dwdata=0x12341234, mem_wreg=0.
REQ-025 LW addr 0x1001 -> no dreq, mem_excp_ale=1, wreg=0, latency 1.
REQ-026 LL then SC with llbit_cur=1 -> LLbit 1 then 0, SC wdata=1; SC with llbit_cur=0 -> no dreq, wdata=0.
REQ-027 flush during WAIT, dack 2 cycles later -> dreq held, no completion; rst=0 mid-WAIT -> dreq=0 immediately.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage. Holds one operation, drives a simple
// request/acknowledge data bus and produces the MEM/WB completion record.
module mem_lsu #(
   parameter int ACK_LIMIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        ex_valid,
   input  logic [3:0]  ex_op,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_sdata,
   input  logic [4:0]  ex_wd,
   input  logic        ex_wreg,
   input  logic [31:0] ex_wdata,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_instr,
   input  logic        llbit_cur,
   output logic        mem_ready,
   output logic        stall_req,
   output logic        dreq,
   output logic        dwe,
   output logic [31:0] daddr,
   output logic [3:0]  dbe,
   output logic [31:0] dwdata,
   input  logic        dack,
   input  logic [31:0] drdata,
   output logic [4:0]  mem_wd,
   output logic        mem_wreg,
   output logic [31:0] mem_wdata,
   output logic [31:0] mem_inst_pc,
   output logic [31:0] mem_instr,
   output logic        mem_inst_valid,
   output logic        mem_LLbit_we,
   output logic        mem_LLbit_value,
   output logic        mem_excp_ale,
   output logic        mem_excp_bus,
   output logic [1:0]  o_dbg_state
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LBU  = 4'd2;
   localparam logic [3:0] OP_LH   = 4'd3;
   localparam logic [3:0] OP_LHU  = 4'd4;
   localparam logic [3:0] OP_LW   = 4'd5;
   localparam logic [3:0] OP_SB   = 4'd6;
   localparam logic [3:0] OP_SH   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;
   localparam logic [3:0] OP_LL   = 4'd9;
   localparam logic [3:0] OP_SC   = 4'd10;

   localparam int CW = (ACK_LIMIT > 0) ? $clog2(ACK_LIMIT + 1) : 1;

   logic [1:0]    r_state;
   logic [3:0]    r_op;
   logic [31:0]   r_addr;
   logic [31:0]   r_sdata;
   logic [4:0]    r_wd;
   logic          r_wreg;
   logic [31:0]   r_wdata;
   logic [31:0]   r_pc;
   logic [31:0]   r_instr;
   logic          r_ale;
   logic          r_sc_fail;
   logic          r_killed;
   logic [CW-1:0] r_cnt;

   logic [3:0]    w_ex_op;
   logic          w_ex_ale;
   logic          w_ex_sc_fail;
   logic          w_ex_exec;
   logic          w_is_load;
   logic          w_is_store;
   logic          w_is_sc;
   logic          w_is_ll;
   logic          w_timeout;
   logic          w_bus_act;
   logic          w_done;
   logic          w_live;
   logic          w_exc;
   logic          w_accept;
   logic [3:0]    w_dbe;
   logic [31:0]   w_dwdata;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load;
   logic [31:0]   w_result;

   // Decode of the offered op: misaligned ops and failing SCs never touch the bus.
   always_comb begin
      w_ex_op = (ex_op > OP_SC) ? OP_NONE : ex_op;
      w_ex_ale = 1'b0;
      case (w_ex_op)
         OP_LH, OP_LHU, OP_SH:       w_ex_ale = ex_addr[0];
         OP_LW, OP_SW, OP_LL, OP_SC: w_ex_ale = |ex_addr[1:0];
         default:                    w_ex_ale = 1'b0;
      endcase
      w_ex_sc_fail = (w_ex_op == OP_SC) & ~llbit_cur & ~w_ex_ale;
      w_ex_exec    = (w_ex_op == OP_NONE) | w_ex_ale | w_ex_sc_fail;
   end

   assign w_is_load  = (r_op == OP_LB) | (r_op == OP_LBU) | (r_op == OP_LH) |
                       (r_op == OP_LHU) | (r_op == OP_LW) | (r_op == OP_LL);
   assign w_is_store = (r_op == OP_SB) | (r_op == OP_SH) | (r_op == OP_SW);
   assign w_is_sc    = (r_op == OP_SC);
   assign w_is_ll    = (r_op == OP_LL);

   // The timeout cycle itself has dreq low, so a late dack there is ignored.
   assign w_timeout = (ACK_LIMIT > 0) && (r_state == S_WAIT) && (r_cnt == CW'(ACK_LIMIT));
   assign w_bus_act = (r_state == S_WAIT) & ~w_timeout;
   assign w_done    = (r_state == S_EXEC) | (w_bus_act & dack) | w_timeout;
   assign w_live    = w_done & ~flush & ~r_killed;
   assign w_exc     = r_ale | w_timeout;

   // A killed WAIT op drains to EMPTY before anything new is taken.
   assign mem_ready = (r_state == S_EMPTY) | (w_done & ~r_killed);
   assign stall_req = ~mem_ready;
   assign w_accept  = ex_valid & mem_ready & ~flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_EMPTY;
         r_op      <= OP_NONE;
         r_addr    <= '0;
         r_sdata   <= '0;
         r_wd      <= '0;
         r_wreg    <= 1'b0;
         r_wdata   <= '0;
         r_pc      <= '0;
         r_instr   <= '0;
         r_ale     <= 1'b0;
         r_sc_fail <= 1'b0;
         r_killed  <= 1'b0;
         r_cnt     <= '0;
      end else if (w_accept) begin
         r_state   <= w_ex_exec ? S_EXEC : S_WAIT;
         r_op      <= w_ex_op;
         r_addr    <= ex_addr;
         r_sdata   <= ex_sdata;
         r_wd      <= ex_wd;
         r_wreg    <= ex_wreg;
         r_wdata   <= ex_wdata;
         r_pc      <= ex_pc;
         r_instr   <= ex_instr;
         r_ale     <= w_ex_ale;
         r_sc_fail <= w_ex_sc_fail;
         r_killed  <= 1'b0;
         r_cnt     <= '0;
      end else if (w_done) begin
         r_state  <= S_EMPTY;
         r_killed <= 1'b0;
         r_cnt    <= '0;
      end else if (r_state == S_WAIT) begin
         if (flush) begin
            r_killed <= 1'b1;
         end
         if (ACK_LIMIT > 0) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_dbe    = 4'b1111;
      w_dwdata = 32'd0;
      case (r_op)
         OP_SB: begin
            w_dbe    = 4'b0001 << r_addr[1:0];
            w_dwdata = {4{r_sdata[7:0]}};
         end
         OP_SH: begin
            w_dbe    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_dwdata = {2{r_sdata[15:0]}};
         end
         OP_SW, OP_SC: w_dwdata = r_sdata;
         default: ;
      endcase
   end

   assign dreq   = w_bus_act;
   assign dwe    = w_bus_act & (w_is_store | w_is_sc);
   assign daddr  = w_bus_act ? {r_addr[31:2], 2'b00} : 32'd0;
   assign dbe    = w_bus_act ? w_dbe : 4'd0;
   assign dwdata = w_bus_act ? w_dwdata : 32'd0;

   // Load data is taken straight from the bus in the dack cycle.
   always_comb begin
      w_byte = drdata[{r_addr[1:0], 3'b000} +: 8];
      w_half = r_addr[1] ? drdata[31:16] : drdata[15:0];
      case (r_op)
         OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  w_load = {24'd0, w_byte};
         OP_LH:   w_load = {{16{w_half[15]}}, w_half};
         OP_LHU:  w_load = {16'd0, w_half};
         default: w_load = drdata;
      endcase
      if (w_exc) begin
         w_result = r_wdata;
      end else if (w_is_load) begin
         w_result = w_load;
      end else if (w_is_sc) begin
         w_result = {31'd0, ~r_sc_fail};
      end else begin
         w_result = r_wdata;
      end
   end

   assign mem_inst_valid  = w_live;
   assign mem_wd          = w_live ? r_wd : 5'd0;
   assign mem_wreg        = w_live & r_wreg & ~w_is_store & ~w_exc;
   assign mem_wdata       = w_live ? w_result : 32'd0;
   assign mem_inst_pc     = w_live ? r_pc : 32'd0;
   assign mem_instr       = w_live ? r_instr : 32'd0;
   assign mem_LLbit_we    = w_live & (w_is_ll | w_is_sc) & ~w_exc;
   assign mem_LLbit_value = w_live & w_is_ll & ~w_exc;
   assign mem_excp_ale    = w_live & r_ale;
   assign mem_excp_bus    = w_live & w_timeout;
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios with inline checks, then random ops
// checked against a behavioural model through a completion scoreboard.
module tb_mem_lsu;

   localparam int ACK_LIMIT = 6;
   localparam int EW = 106;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        ex_valid;
   logic [3:0]  ex_op;
   logic [31:0] ex_addr, ex_sdata, ex_wdata, ex_pc, ex_instr;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic        llbit_cur;
   logic        mem_ready, stall_req, dreq, dwe;
   logic [31:0] daddr, dwdata;
   logic [3:0]  dbe;
   logic        dack;
   logic [31:0] drdata;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata, mem_inst_pc, mem_instr;
   logic        mem_inst_valid, mem_LLbit_we, mem_LLbit_value;
   logic        mem_excp_ale, mem_excp_bus;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [EW-1:0] exp_q[$];
   bit sb_en = 1'b0;
   logic [EW-1:0] sb_exp, sb_got;

   mem_lsu #(.ACK_LIMIT(ACK_LIMIT)) dut (
      .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_op(ex_op),
      .ex_addr(ex_addr), .ex_sdata(ex_sdata), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
      .ex_wdata(ex_wdata), .ex_pc(ex_pc), .ex_instr(ex_instr), .llbit_cur(llbit_cur),
      .mem_ready(mem_ready), .stall_req(stall_req), .dreq(dreq), .dwe(dwe),
      .daddr(daddr), .dbe(dbe), .dwdata(dwdata), .dack(dack), .drdata(drdata),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_inst_pc(mem_inst_pc), .mem_instr(mem_instr), .mem_inst_valid(mem_inst_valid),
      .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
      .mem_excp_ale(mem_excp_ale), .mem_excp_bus(mem_excp_bus), .o_dbg_state(dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ex_valid = 1'b0; ex_op = 4'd0; ex_addr = '0; ex_sdata = '0; ex_wd = '0;
      ex_wreg = 1'b0; ex_wdata = '0; ex_pc = '0; ex_instr = '0;
      flush = 1'b0; dack = 1'b0;
   endtask

   task automatic set_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic [31:0] pc);
      ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_sdata = sdata; ex_wd = wd;
      ex_wreg = wreg; ex_wdata = wdata; ex_pc = pc; ex_instr = pc ^ 32'h5A5A0000;
   endtask

   // ---------------- reference model ----------------
   function automatic bit model_ale(input logic [3:0] op, input logic [31:0] addr);
      int unsigned off = addr % 4;
      if (op == 3 || op == 4 || op == 7) return (off % 2) != 0;
      if (op == 5 || op == 8 || op == 9 || op == 10) return off != 0;
      return 1'b0;
   endfunction

   // {uses_bus, dwe, dbe[3:0], dwdata[31:0]}
   function automatic logic [37:0] model_bus(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] sdata, input logic llbit);
      int unsigned off = addr % 4;
      bit is_ld = (op >= 1 && op <= 5) || op == 9;
      bit is_st = (op >= 6 && op <= 8);
      bit uses = !model_ale(op, addr) && (is_ld || is_st || (op == 10 && llbit));
      logic [3:0] be = 4'hF;
      logic [31:0] wd = sdata;
      if (op == 6) begin
         be = 4'(1 << off);
         wd = (sdata % 256) * 32'h01010101;
      end else if (op == 7) begin
         be = (off >= 2) ? 4'hC : 4'h3;
         wd = (sdata % 65536) * 32'h00010001;
      end
      return {uses, is_st || op == 10, be, wd};
   endfunction

   // {wd, wreg, wdata, ll_we, ll_val, ale, bus, pc, instr}
   function automatic logic [EW-1:0] model_done(input logic [3:0] op, input logic [31:0] addr,
         input logic [31:0] wdata_in, input logic [31:0] rd, input logic [4:0] wd,
         input logic wreg, input logic llbit, input logic [31:0] pc);
      int unsigned off = addr % 4;
      logic [31:0] byte_v = (rd >> (8 * off)) % 256;
      logic [31:0] half_v = (off >= 2) ? (rd >> 16) : (rd % 65536);
      bit ale = model_ale(op, addr);
      logic [31:0] res = wdata_in;
      bit we = wreg;
      bit ll_we = 1'b0;
      bit ll_v = 1'b0;
      half_v = half_v % 65536;
      if (ale) begin
         we = 1'b0;
      end else begin
         case (op)
            4'd1: res = (byte_v >= 128) ? byte_v - 256 : byte_v;
            4'd2: res = byte_v;
            4'd3: res = (half_v >= 32768) ? half_v - 65536 : half_v;
            4'd4: res = half_v;
            4'd5: res = rd;
            4'd6, 4'd7, 4'd8: we = 1'b0;
            4'd9: begin res = rd; ll_we = 1'b1; ll_v = 1'b1; end
            4'd10: begin res = llbit ? 32'd1 : 32'd0; ll_we = 1'b1; end
            default: res = wdata_in;
         endcase
      end
      return {wd, we, res, ll_we, ll_v, ale, 1'b0, pc, pc ^ 32'h5A5A0000};
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (sb_en && mem_inst_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected: got completion pc=%h want none", mem_inst_pc);
         end else begin
            sb_exp = exp_q.pop_front();
            sb_got = {mem_wd, mem_wreg, mem_wdata, mem_LLbit_we, mem_LLbit_value,
                      mem_excp_ale, mem_excp_bus, mem_inst_pc, mem_instr};
            if (sb_exp[65] || sb_exp[64]) begin
               sb_exp[99:68] = '0;
               sb_got[99:68] = '0;
            end
            if (sb_got !== sb_exp) begin
               n_errors++;
               $display("FAIL sb_completion: got %h want %h", sb_got, sb_exp);
            end
         end
      end
   end

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      llbit_cur = 1'b0;
      drdata = '0;
      repeat (3) tick();
      n_checks++; if (mem_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b want 1", mem_ready); end
      n_checks++; if (stall_req !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %b want 0", stall_req); end
      n_checks++; if ({dreq, dwe, daddr, dbe, dwdata} !== '0) begin n_errors++; $display("FAIL rst_bus: got dreq=%b daddr=%h dbe=%h want all 0", dreq, daddr, dbe); end
      n_checks++; if ({mem_inst_valid, mem_wreg, mem_wdata, mem_LLbit_we, mem_excp_ale, mem_excp_bus} !== '0) begin n_errors++; $display("FAIL rst_outs: got valid=%b wdata=%h want 0", mem_inst_valid, mem_wdata); end
   endtask

   task automatic test_none_first_accept();
      set_op(4'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h5, 32'h100);
      rst = 1'b1;
      #1;
      n_checks++; if (mem_ready !== 1'b1) begin n_errors++; $display("FAIL none_ready: got %b want 1", mem_ready); end
      tick();
      idle_inputs();
      #1;
      n_checks++; if ({mem_inst_valid, mem_wreg, mem_wd, mem_wdata} !== {1'b1, 1'b1, 5'd3, 32'h5}) begin n_errors++; $display("FAIL none_done: got valid=%b wreg=%b wd=%0d wdata=%h want 1 1 3 00000005", mem_inst_valid, mem_wreg, mem_wd, mem_wdata); end
      n_checks++; if (dreq !== 1'b0) begin n_errors++; $display("FAIL none_dreq: got %b want 0", dreq); end
      n_checks++; if (mem_inst_pc !== 32'h100) begin n_errors++; $display("FAIL none_pc: got %h want 00000100", mem_inst_pc); end
      tick();
      #1;
      n_checks++; if (mem_inst_valid !== 1'b0) begin n_errors++; $display("FAIL none_after: got %b want 0", mem_inst_valid); end
   endtask

   task automatic test_lb_wait();
      int stalls = 0;
      set_op(4'd1, 32'h1003, 32'h0, 5'd7, 1'b1, 32'hDEAD, 32'h200);
      tick();
      idle_inputs();
      #1;
      n_checks++; if ({daddr, dbe, dwe} !== {32'h1000, 4'hF, 1'b0}) begin n_errors++; $display("FAIL lb_bus: got daddr=%h dbe=%h dwe=%b want 00001000 f 0", daddr, dbe, dwe); end
      for (int i = 0; i < 3; i++) begin
         if (stall_req === 1'b1 && dreq === 1'b1 && mem_inst_valid === 1'b0) stalls++;
         tick();
         #1;
      end
      n_checks++; if (stalls != 3) begin n_errors++; $display("FAIL lb_stall: got %0d stall cycles want 3", stalls); end
      dack = 1'b1;
      drdata = 32'h80112233;
      #1;
      n_checks++; if ({mem_inst_valid, mem_wreg, mem_wd, mem_wdata} !== {1'b1, 1'b1, 5'd7, 32'hFFFFFF80}) begin n_errors++; $display("FAIL lb_done: got valid=%b wreg=%b wd=%0d wdata=%h want 1 1 7 ffffff80", mem_inst_valid, mem_wreg, mem_wd, mem_wdata); end
      n_checks++; if (stall_req !== 1'b0) begin n_errors++; $display("FAIL lb_stall_end: got %b want 0", stall_req); end
      tick();
      dack = 1'b0;
   endtask

   task automatic test_sh_store();
      set_op(4'd7, 32'h2002, 32'hABCD1234, 5'd9, 1'b1, 32'h77, 32'h300);
      tick();
      idle_inputs();
      dack = 1'b1;
      #1;
      n_checks++; if ({dreq, dwe, dbe, dwdata, daddr} !== {1'b1, 1'b1, 4'hC, 32'h12341234, 32'h2000}) begin n_errors++; $display("FAIL sh_bus: got dreq=%b dwe=%b dbe=%h dwdata=%h daddr=%h want 1 1 c 12341234 00002000", dreq, dwe, dbe, dwdata, daddr); end
      n_checks++; if ({mem_inst_valid, mem_wreg} !== 2'b10) begin n_errors++; $display("FAIL sh_done: got valid=%b wreg=%b want 1 0", mem_inst_valid, mem_wreg); end
      tick();
      dack = 1'b0;
   endtask

   task automatic test_misaligned();
      set_op(4'd5, 32'h1001, 32'h0, 5'd2, 1'b1, 32'h1, 32'h400);
      tick();
      idle_inputs();
      #1;
      n_checks++; if (dreq !== 1'b0) begin n_errors++; $display("FAIL ale_dreq: got %b want 0", dreq); end
      n_checks++; if ({mem_inst_valid, mem_excp_ale, mem_wreg, mem_LLbit_we, mem_excp_bus} !== 5'b11000) begin n_errors++; $display("FAIL ale_done: got valid=%b ale=%b wreg=%b llwe=%b bus=%b want 1 1 0 0 0", mem_inst_valid, mem_excp_ale, mem_wreg, mem_LLbit_we, mem_excp_bus); end
      tick();
   endtask

   task automatic test_ll_sc();
      llbit_cur = 1'b0;
      set_op(4'd9, 32'h3000, 32'h0, 5'd4, 1'b1, 32'h0, 32'h500);
      tick();
      idle_inputs();
      dack = 1'b1;
      drdata = 32'hCAFEF00D;
      #1;
      n_checks++; if ({mem_inst_valid, mem_LLbit_we, mem_LLbit_value, mem_wdata} !== {3'b111, 32'hCAFEF00D}) begin n_errors++; $display("FAIL ll_done: got valid=%b llwe=%b llv=%b wdata=%h want 1 1 1 cafef00d", mem_inst_valid, mem_LLbit_we, mem_LLbit_value, mem_wdata); end
      tick();
      dack = 1'b0;
      llbit_cur = 1'b1;
      set_op(4'd10, 32'h3000, 32'h11, 5'd5, 1'b1, 32'h99, 32'h504);
      tick();
      idle_inputs();
      dack = 1'b1;
      #1;
      n_checks++; if ({dreq, dwe, dbe} !== {2'b11, 4'hF}) begin n_errors++; $display("FAIL sc_bus: got dreq=%b dwe=%b dbe=%h want 1 1 f", dreq, dwe, dbe); end
      n_checks++; if ({mem_inst_valid, mem_wreg, mem_wdata, mem_LLbit_we, mem_LLbit_value} !== {2'b11, 32'd1, 2'b10}) begin n_errors++; $display("FAIL sc_ok: got valid=%b wreg=%b wdata=%h llwe=%b llv=%b want 1 1 1 1 0", mem_inst_valid, mem_wreg, mem_wdata, mem_LLbit_we, mem_LLbit_value); end
      tick();
      dack = 1'b0;
      llbit_cur = 1'b0;
      set_op(4'd10, 32'h3000, 32'h11, 5'd5, 1'b1, 32'h99, 32'h508);
      tick();
      idle_inputs();
      #1;
      n_checks++; if (dreq !== 1'b0) begin n_errors++; $display("FAIL scf_dreq: got %b want 0", dreq); end
      n_checks++; if ({mem_inst_valid, mem_wdata, mem_LLbit_we, mem_LLbit_value} !== {1'b1, 32'd0, 2'b10}) begin n_errors++; $display("FAIL scf_done: got valid=%b wdata=%h llwe=%b llv=%b want 1 0 1 0", mem_inst_valid, mem_wdata, mem_LLbit_we, mem_LLbit_value); end
      tick();
   endtask

   task automatic test_flush_wait();
      int leaked = 0;
      int held = 0;
      set_op(4'd5, 32'h4000, 32'h0, 5'd6, 1'b1, 32'h0, 32'h600);
      tick();
      idle_inputs();
      flush = 1'b1;
      #1;
      if (dreq === 1'b1) held++;
      if (mem_inst_valid !== 1'b0) leaked++;
      tick();
      flush = 1'b0;
      #1;
      if (dreq === 1'b1) held++;
      if (mem_inst_valid !== 1'b0) leaked++;
      tick();
      dack = 1'b1;
      drdata = 32'h12345678;
      #1;
      if (dreq === 1'b1) held++;
      if (mem_inst_valid !== 1'b0) leaked++;
      n_checks++; if (held != 3) begin n_errors++; $display("FAIL flushw_dreq: got %0d dreq cycles want 3", held); end
      n_checks++; if (leaked != 0) begin n_errors++; $display("FAIL flushw_bubble: got %0d completions want 0", leaked); end
      tick();
      dack = 1'b0;
      #1;
      n_checks++; if ({dreq, mem_ready, mem_inst_valid} !== 3'b010) begin n_errors++; $display("FAIL flushw_empty: got dreq=%b ready=%b valid=%b want 0 1 0", dreq, mem_ready, mem_inst_valid); end
   endtask

   task automatic test_flush_exec();
      set_op(4'd0, 32'h0, 32'h0, 5'd1, 1'b1, 32'h11, 32'h700);
      tick();
      set_op(4'd0, 32'h0, 32'h0, 5'd2, 1'b1, 32'h22, 32'h704);
      flush = 1'b1;
      #1;
      n_checks++; if (mem_inst_valid !== 1'b0) begin n_errors++; $display("FAIL flushx_kill: got valid=%b want 0", mem_inst_valid); end
      tick();
      idle_inputs();
      #1;
      n_checks++; if ({mem_inst_valid, mem_ready} !== 2'b01) begin n_errors++; $display("FAIL flushx_noaccept: got valid=%b ready=%b want 0 1", mem_inst_valid, mem_ready); end
   endtask

   task automatic test_timeout();
      int cnt = 0;
      set_op(4'd5, 32'h5000, 32'h0, 5'd8, 1'b1, 32'h0, 32'h800);
      tick();
      idle_inputs();
      for (int i = 0; i < 20; i++) begin
         #1;
         if (dreq !== 1'b1) break;
         cnt++;
         tick();
      end
      n_checks++; if (cnt != ACK_LIMIT) begin n_errors++; $display("FAIL tmo_cycles: got %0d dreq cycles want %0d", cnt, ACK_LIMIT); end
      n_checks++; if ({mem_inst_valid, mem_excp_bus, mem_wreg, mem_LLbit_we} !== 4'b1100) begin n_errors++; $display("FAIL tmo_done: got valid=%b bus=%b wreg=%b llwe=%b want 1 1 0 0", mem_inst_valid, mem_excp_bus, mem_wreg, mem_LLbit_we); end
      tick();
      #1;
      n_checks++; if ({dreq, mem_ready} !== 2'b01) begin n_errors++; $display("FAIL tmo_empty: got dreq=%b ready=%b want 0 1", dreq, mem_ready); end
   endtask

   task automatic test_reset_wait();
      set_op(4'd5, 32'h6000, 32'h0, 5'd8, 1'b1, 32'h0, 32'h900);
      tick();
      idle_inputs();
      #1;
      n_checks++; if (dreq !== 1'b1) begin n_errors++; $display("FAIL rstw_pre: got dreq=%b want 1", dreq); end
      rst = 1'b0;
      #1;
      n_checks++; if ({dreq, mem_ready, stall_req} !== 3'b010) begin n_errors++; $display("FAIL rstw_async: got dreq=%b ready=%b stall=%b want 0 1 0", dreq, mem_ready, stall_req); end
      tick();
      rst = 1'b1;
   endtask

   task automatic test_back_to_back();
      set_op(4'd0, 32'h0, 32'h0, 5'd1, 1'b1, 32'hA, 32'hA00);
      tick();
      set_op(4'd0, 32'h0, 32'h0, 5'd2, 1'b1, 32'hB, 32'hA04);
      #1;
      n_checks++; if ({mem_inst_valid, mem_ready, mem_wdata} !== {2'b11, 32'hA}) begin n_errors++; $display("FAIL b2b_first: got valid=%b ready=%b wdata=%h want 1 1 0000000a", mem_inst_valid, mem_ready, mem_wdata); end
      tick();
      idle_inputs();
      #1;
      n_checks++; if ({mem_inst_valid, mem_wd, mem_wdata} !== {1'b1, 5'd2, 32'hB}) begin n_errors++; $display("FAIL b2b_second: got valid=%b wd=%0d wdata=%h want 1 2 0000000b", mem_inst_valid, mem_wd, mem_wdata); end
      tick();
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] addr, sdata, rd;
      logic [37:0] bus;
      int          dly;
      int          bus_bad = 0;
      sb_en = 1'b1;
      for (int n = 0; n < 80; n++) begin
         op = 4'($urandom_range(0, 15));
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         sdata = $urandom;
         rd = $urandom;
         llbit_cur = 1'($urandom_range(0, 1));
         set_op(op, addr, sdata, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                $urandom, 32'h10000 + 32'(n * 4));
         #1;
         n_checks++; if (mem_ready !== 1'b1) begin n_errors++; $display("FAIL rnd_ready: got %b want 1 at op %0d", mem_ready, n); end
         bus = model_bus(op, addr, sdata, llbit_cur);
         exp_q.push_back(model_done(op, addr, ex_wdata, rd, ex_wd, ex_wreg, llbit_cur, ex_pc));
         tick();
         idle_inputs();
         if (bus[37]) begin
            dly = $urandom_range(0, 4);
            for (int d = 0; d <= dly; d++) begin
               if (d == dly) begin
                  dack = 1'b1;
                  drdata = rd;
               end else begin
                  drdata = $urandom;
               end
               #1;
               if (dreq !== 1'b1 || daddr !== addr - (addr % 4) || dbe !== bus[35:32] ||
                   dwe !== bus[36] || (bus[36] && dwdata !== bus[31:0])) begin
                  bus_bad++;
                  $display("FAIL rnd_bus: got dreq=%b daddr=%h dbe=%h dwe=%b dwdata=%h want 1 %h %h %b %h (op %0d)",
                           dreq, daddr, dbe, dwe, dwdata, addr - (addr % 4), bus[35:32], bus[36], bus[31:0], op);
               end
               tick();
            end
            dack = 1'b0;
         end else begin
            #1;
            n_checks++; if (dreq !== 1'b0) begin n_errors++; $display("FAIL rnd_nobus: got dreq=%b want 0 (op %0d)", dreq, op); end
            tick();
         end
      end
      tick();
      sb_en = 1'b0;
      n_checks++; if (bus_bad != 0) begin n_errors++; $display("FAIL rnd_bus_total: got %0d bad bus cycles want 0", bus_bad); end
      n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL rnd_missing: got %0d uncompleted ops want 0", exp_q.size()); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_none_first_accept();
      test_lb_wait();
      test_sh_store();
      test_misaligned();
      test_ll_sc();
      test_flush_wait();
      test_flush_exec();
      test_timeout();
      test_back_to_back();
      test_reset_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
